com_rs: RTL and testbench

- Responder end of the collector command link; sits between the com PHY layer and the local application.
- Accepts command frames tagged with an alternating sequence type, delivers new commands to the application exactly once and discards duplicates.
- Answers every valid frame with a reply whose type alternates between RX00 and RX01 on each newly accepted command.
- A requester that retries on timeout and checks reply-type toggling therefore sees exactly-once delivery.

---
 rtl/com_rs_if.sv | 25 ++
 rtl/com_rs.sv | 132 +++++++++++++
 tb/tb_com_rs.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/com_rs_if.sv
// Handshake bundle between the com PHY, the com_rs responder and the application.
interface com_rs_if;
  logic       fs_com_read;
  logic       fd_com_read;
  logic [3:0] btype_in;
  logic       fs_com_send;
  logic       fd_com_send;
  logic [3:0] btype_out;
  logic       fs_read;
  logic       fd_read;
  logic [7:0] dup_cnt;
  logic [7:0] err_cnt;

  // Responder side (com_rs itself)
  modport slave (
    input  fs_com_read, btype_in, fd_com_send, fd_read,
    output fd_com_read, fs_com_send, btype_out, fs_read, dup_cnt, err_cnt
  );

  // Environment side (PHY plus application)
  modport master (
    output fs_com_read, btype_in, fd_com_send, fd_read,
    input  fd_com_read, fs_com_send, btype_out, fs_read, dup_cnt, err_cnt
  );
endinterface

// File: rtl/com_rs.sv
// Responder end of the collector command link: delivers each new command
// exactly once, drops duplicates, and answers every valid frame with a reply
// type that toggles between RX00 and RX01 on each newly accepted command.
module com_rs #(
  parameter logic [3:0]  NUM_LATENCY = 4'h4,
  parameter logic [11:0] TIMEOUT     = 12'h400
) (
  input  logic     clk,
  input  logic     rst,
  com_rs_if.slave  bus
);

  localparam logic [3:0] CMD0     = 4'h5;
  localparam logic [3:0] CMD1     = 4'hA;
  localparam logic [3:0] COM_INIT = 4'h0;
  localparam logic [3:0] RX00     = 4'h2;
  localparam logic [3:0] RX01     = 4'hD;

  typedef enum logic [7:0] {
    MAIN_IDLE  = 8'b0000_0001,
    MAIN_WAIT  = 8'b0000_0010,
    READ_TAKE  = 8'b0000_0100,
    READ_WAIT  = 8'b0000_1000,
    READ_DONE  = 8'b0001_0000,
    REPLY_WORK = 8'b0010_0000,
    SEND_WAIT  = 8'b0100_0000,
    SEND_DONE  = 8'b1000_0000
  } state_t;

  localparam logic [11:0] LAT_LAST = {8'd0, NUM_LATENCY} - 12'd1;
  localparam logic [11:0] TO_LAST  = TIMEOUT - 12'd1;

  state_t      state, state_d;
  logic [11:0] num, num_d;
  logic [3:0]  rx_type;
  logic        last_seq_vld;
  logic        last_seq;
  logic [3:0]  last_rep;
  logic [7:0]  dup_cnt_q, err_cnt_q;

  logic type_valid, in_seq, is_dup, rx_invalid, timeout_hit, err_inc;

  assign type_valid  = (bus.btype_in == CMD0) || (bus.btype_in == CMD1);
  assign in_seq      = (bus.btype_in == CMD1);
  assign is_dup      = last_seq_vld && (in_seq == last_seq);
  // rx_type was captured in READ_TAKE; an invalid type means no reply is sent.
  assign rx_invalid  = (rx_type != CMD0) && (rx_type != CMD1);
  assign timeout_hit = (state == SEND_WAIT) && !bus.fd_com_send && (num >= TO_LAST);
  assign err_inc     = ((state == READ_TAKE) && !type_valid) || timeout_hit;

  // Next-state and wait-counter decode.
  always_comb begin
    // NOTE: every signal gets a default first so no path leaves it unassigned and no latch is inferred.
    state_d = state;
    num_d   = 12'd0;
    case (state)
      MAIN_IDLE:  state_d = MAIN_WAIT;
      MAIN_WAIT:  if (bus.fs_com_read) state_d = READ_TAKE;
      READ_TAKE:  state_d = (!type_valid || is_dup) ? READ_DONE : READ_WAIT;
      READ_WAIT:  if (bus.fd_read) state_d = READ_DONE;
      READ_DONE: begin
        if (!bus.fs_com_read) begin
          if (rx_invalid)               state_d = MAIN_WAIT;
          else if (NUM_LATENCY == 4'd0) state_d = SEND_WAIT;
          else                          state_d = REPLY_WORK;
        end
      end
      REPLY_WORK: begin
        if (num >= LAT_LAST) state_d = SEND_WAIT;
        else                 num_d   = num + 12'd1;
      end
      SEND_WAIT: begin
        if (bus.fd_com_send) state_d = SEND_DONE;
        else if (timeout_hit) state_d = MAIN_WAIT;
        else                  num_d   = num + 12'd1;
      end
      SEND_DONE:  if (!bus.fd_com_send) state_d = MAIN_WAIT;
      default:    state_d = MAIN_IDLE;
    endcase
  end

  // State and wait-counter registers.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: non-blocking assignments so every register in the design samples pre-edge values.
    if (rst) begin
      state <= MAIN_IDLE;
      num   <= 12'd0;
    end else begin
      state <= state_d;
      num   <= num_d;
    end
  end

  // Frame classification, sequence tracking and reply-type toggling.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_type      <= COM_INIT;
      last_seq_vld <= 1'b0;
      last_seq     <= 1'b0;
      last_rep     <= COM_INIT;
    end else if (state == READ_TAKE) begin
      rx_type <= bus.btype_in;
      if (type_valid && !is_dup) begin
        last_seq_vld <= 1'b1;
        last_seq     <= in_seq;
        last_rep     <= (last_rep == RX00) ? RX01 : RX00;
      end
    end
  end

  // Saturating duplicate and error counters.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dup_cnt_q <= 8'd0;
      err_cnt_q <= 8'd0;
    end else begin
      if ((state == READ_TAKE) && type_valid && is_dup && (dup_cnt_q != 8'hFF))
        dup_cnt_q <= dup_cnt_q + 8'd1;
      if (err_inc && (err_cnt_q != 8'hFF))
        err_cnt_q <= err_cnt_q + 8'd1;
    end
  end

  // Moore handshake outputs; the reply type always shows the last chosen reply.
  assign bus.fs_read     = (state == READ_WAIT);
  assign bus.fd_com_read = (state == READ_DONE);
  assign bus.fs_com_send = (state == SEND_WAIT);
  assign bus.btype_out   = last_rep;
  assign bus.dup_cnt     = dup_cnt_q;
  assign bus.err_cnt     = err_cnt_q;

endmodule

// File: tb/tb_com_rs.sv
// Bench for com_rs: a transaction-level model of the exactly-once protocol,
// a per-cycle compare process, and directed frame sequences.
module tb_com_rs;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  com_rs_if bus ();
  com_rs_if bus0 ();

  com_rs #(.NUM_LATENCY(4'h4), .TIMEOUT(12'h400)) u_dut  (.clk(clk), .rst(rst), .bus(bus));
  com_rs #(.NUM_LATENCY(4'h0), .TIMEOUT(12'h400)) u_dut0 (.clk(clk), .rst(rst), .bus(bus0));

  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, got, exp);
  endtask

  // Protocol model: sequence memory, reply memory, expected counters.
  int         m_last_seq;
  logic [3:0] m_last_rep;
  int         exp_dup, exp_err;
  bit         cur_new, cur_reply;
  logic [3:0] cur_rep;
  bit         chk_en = 1'b0;

  function automatic void model_reset();
    m_last_seq = -1;
    m_last_rep = 4'h0;
    exp_dup    = 0;
    exp_err    = 0;
    cur_new    = 1'b0;
    cur_reply  = 1'b0;
    cur_rep    = 4'h0;
  endfunction

  function automatic void model_frame(input logic [3:0] t);
    int seq;
    if (t != 4'h5 && t != 4'hA) begin
      exp_err   = (exp_err < 255) ? exp_err + 1 : 255;
      cur_new   = 1'b0;
      cur_reply = 1'b0;
    end else begin
      seq = (t == 4'hA) ? 1 : 0;
      if (seq == m_last_seq) begin
        exp_dup = (exp_dup < 255) ? exp_dup + 1 : 255;
        cur_new = 1'b0;
      end else begin
        m_last_seq = seq;
        m_last_rep = (m_last_rep == 4'h2) ? 4'hD : 4'h2;
        cur_new    = 1'b1;
      end
      cur_reply = 1'b1;
    end
    cur_rep = m_last_rep;
  endfunction

  // Per-cycle compare against the model while outputs are meaningful.
  logic prev_fs_read = 1'b0;
  int   cnt_fs_read  = 0;
  always @(negedge clk) begin
    if (rst) begin
      prev_fs_read <= 1'b0;
    end else if (chk_en) begin
      if (bus.fd_com_read) begin
        check("dup_cnt_in_read_done", bus.dup_cnt, exp_dup);
        check("err_cnt_in_read_done", bus.err_cnt, exp_err);
      end
      if (bus.fs_com_send) begin
        check("send_allowed", bus.fs_com_send, cur_reply);
        check("btype_out_in_send", bus.btype_out, cur_rep);
      end
      if (bus.fs_read) check("fs_read_only_new", bus.fs_read, cur_new);
      if (bus.fs_read && !prev_fs_read) cnt_fs_read <= cnt_fs_read + 1;
      prev_fs_read <= bus.fs_read;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // One complete frame exchange on the NUM_LATENCY=4 instance.
  task automatic do_frame(input logic [3:0] t, input int rd_delay, input bit hang,
                          output logic [3:0] got_rep);
    int k;
    bit seen;
    got_rep = 4'hF;
    model_frame(t);
    tick();
    bus.btype_in    = t;
    bus.fs_com_read = 1'b1;
    tick();
    check("take_no_fs_read", bus.fs_read, 1'b0);
    check("take_no_fd_com_read", bus.fd_com_read, 1'b0);
    tick();
    if (cur_new) begin
      check("fs_read_latency", bus.fs_read, 1'b1);
      repeat (rd_delay) tick();
      check("fs_read_held", bus.fs_read, 1'b1);
      bus.fd_read = 1'b1;
      tick();
      bus.fd_read = 1'b0;
      check("fd_com_read_after_fd_read", bus.fd_com_read, 1'b1);
      check("fs_read_cleared", bus.fs_read, 1'b0);
    end else begin
      check("no_fs_read", bus.fs_read, 1'b0);
      check("fd_com_read_direct", bus.fd_com_read, 1'b1);
    end
    repeat (2) begin
      tick();
      check("fd_com_read_held", bus.fd_com_read, 1'b1);
    end
    bus.fs_com_read = 1'b0;
    if (!cur_reply) begin
      tick();
      check("fd_com_read_released", bus.fd_com_read, 1'b0);
      repeat (8) begin
        tick();
        check("no_reply_send", bus.fs_com_send, 1'b0);
      end
    end else begin
      k    = 0;
      seen = 1'b0;
      while (!seen && k < 40) begin
        tick();
        k++;
        if (k == 1) check("fd_com_read_released", bus.fd_com_read, 1'b0);
        seen = bus.fs_com_send;
      end
      check("send_latency", k, 5);
      got_rep = bus.btype_out;
      if (!hang) begin
        bus.fd_com_send = 1'b1;
        tick();
        check("send_done_drop", bus.fs_com_send, 1'b0);
        tick();
        bus.fd_com_send = 1'b0;
        tick();
      end else begin
        k = 1;
        while (k < 2000) begin
          tick();
          if (!bus.fs_com_send) break;
          k++;
        end
        check("timeout_cycles", k, 1024);
        exp_err = (exp_err < 255) ? exp_err + 1 : 255;
      end
    end
    repeat (2) tick();
    check("idle_dup_cnt", bus.dup_cnt, exp_dup);
    check("idle_err_cnt", bus.err_cnt, exp_err);
  endtask

  initial begin
    logic [3:0] rep;
    bus.fs_com_read  = 1'b0; bus.btype_in  = 4'h0; bus.fd_com_send  = 1'b0; bus.fd_read  = 1'b0;
    bus0.fs_com_read = 1'b0; bus0.btype_in = 4'h0; bus0.fd_com_send = 1'b0; bus0.fd_read = 1'b0;
    model_reset();
    repeat (3) tick();
    rst = 1'b0;

    // Reset state
    check("rst_fs_read", bus.fs_read, 1'b0);
    check("rst_fd_com_read", bus.fd_com_read, 1'b0);
    check("rst_fs_com_send", bus.fs_com_send, 1'b0);
    check("rst_btype_out", bus.btype_out, 4'h0);
    check("rst_dup_cnt", bus.dup_cnt, 8'h00);
    check("rst_err_cnt", bus.err_cnt, 8'h00);
    chk_en = 1'b1;

    // First CMD0: new, reply RX00
    do_frame(4'h5, 3, 1'b0, rep);
    check("t1_reply_rx00", rep, 4'h2);
    check("t1_dup_zero", bus.dup_cnt, 8'h00);

    // CMD1 then CMD0: alternating replies
    do_frame(4'hA, 1, 1'b0, rep);
    check("t2_reply_rx01", rep, 4'hD);
    do_frame(4'h5, 0, 1'b0, rep);
    check("t2_reply_rx00", rep, 4'h2);
    check("t2_three_fs_read", cnt_fs_read, 3);

    // Repeated CMD0: duplicate, same reply
    do_frame(4'h5, 0, 1'b0, rep);
    check("t3_dup_reply", rep, 4'h2);
    check("t3_dup_cnt", bus.dup_cnt, 8'h01);
    check("t3_no_new_fs_read", cnt_fs_read, 3);

    // Invalid type: consumed, no reply
    do_frame(4'h7, 0, 1'b0, rep);
    check("t4_err_cnt", bus.err_cnt, 8'h01);
    check("t4_no_fs_read", cnt_fs_read, 3);

    // Reply timeout, then the retried CMD1 is a duplicate with the same reply
    do_frame(4'hA, 0, 1'b1, rep);
    check("t5_reply_rx01", rep, 4'hD);
    check("t5_err_cnt", bus.err_cnt, 8'h02);
    do_frame(4'hA, 0, 1'b0, rep);
    check("t5_retry_reply", rep, 4'hD);
    check("t5_retry_dup_cnt", bus.dup_cnt, 8'h02);

    // Reset while the application holds the command
    model_frame(4'h5);
    tick();
    bus.btype_in    = 4'h5;
    bus.fs_com_read = 1'b1;
    repeat (2) tick();
    check("t6_in_read_wait", bus.fs_read, 1'b1);
    rst = 1'b1;
    #1;
    check("t6_fs_read_clear", bus.fs_read, 1'b0);
    check("t6_fd_com_read_clear", bus.fd_com_read, 1'b0);
    check("t6_fs_com_send_clear", bus.fs_com_send, 1'b0);
    check("t6_btype_out_init", bus.btype_out, 4'h0);
    check("t6_dup_cnt_clear", bus.dup_cnt, 8'h00);
    check("t6_err_cnt_clear", bus.err_cnt, 8'h00);
    model_reset();
    bus.fs_com_read = 1'b0;
    repeat (2) tick();
    rst = 1'b0;
    do_frame(4'hA, 0, 1'b0, rep);
    check("t6_cmd1_after_rst_rx00", rep, 4'h2);

    // Error counter saturation
    for (int i = 0; i < 260; i++) do_frame(4'hF, 0, 1'b0, rep);
    check("t7_err_saturated", bus.err_cnt, 8'hFF);

    // NUM_LATENCY=0 instance: reply request the cycle after fs_com_read falls
    tick();
    bus0.btype_in    = 4'h5;
    bus0.fs_com_read = 1'b1;
    repeat (2) tick();
    check("t8_fs_read", bus0.fs_read, 1'b1);
    bus0.fd_read = 1'b1;
    tick();
    bus0.fd_read = 1'b0;
    check("t8_fd_com_read", bus0.fd_com_read, 1'b1);
    check("t8_no_early_send", bus0.fs_com_send, 1'b0);
    bus0.fs_com_read = 1'b0;
    tick();
    check("t8_send_next_cycle", bus0.fs_com_send, 1'b1);
    check("t8_reply_rx00", bus0.btype_out, 4'h2);
    bus0.fd_com_send = 1'b1;
    tick();
    check("t8_send_done", bus0.fs_com_send, 1'b0);
    bus0.fd_com_send = 1'b0;
    repeat (2) tick();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
